// File: rtl/rfphoenix_branch_resolve_pkg.sv
// Shared types and defaults for the branch-resolve stage and its target calculator.
package rfphoenix_branch_resolve_pkg;

    localparam int BR_NTHREADS    = 4;
    localparam int BR_TIDW        = $clog2(BR_NTHREADS);
    localparam int BR_AWID        = 32;
    localparam int BR_DWID        = 21;
    localparam int INSN_BYTES_DEF = 5;
    localparam int FLUSH_CYC_DEF  = 2;

    typedef enum logic [1:0] {
        BRS_IDLE,
        BRS_REDIRECT,
        BRS_FLUSH
    } br_resolve_state_e;

    // One resolved branch as presented by the evaluator (default widths).
    typedef struct packed {
        logic [BR_TIDW-1:0] tid;
        logic [BR_AWID-1:0] pc;
        logic [BR_DWID-1:0] disp;
        logic               taken;
        logic               pred_taken;
        logic [BR_AWID-1:0] pred_tgt;
    } br_resolve_req_t;

endpackage

// File: rtl/rfphoenix_branch_resolve_if.sv
// Evaluator-to-resolve handshake, redirect-to-fetch, flush and predictor update signals.
interface rfphoenix_branch_resolve_if #(
    parameter int NTHREADS = 4,
    parameter int AWID     = 32,
    parameter int DWID     = 21
);
    localparam int TIDW = $clog2(NTHREADS);

    // A branch transfers on a cycle with br_valid & br_ready; br_valid seen while
    // br_ready=0 is dropped, so the producer must hold it. A redirect transfers on
    // redirect_valid & redirect_ack; redirect fields are stable until then.
    logic            br_valid;
    logic            br_ready;
    logic [TIDW-1:0] br_tid;
    logic [AWID-1:0] br_pc;
    logic [DWID-1:0] br_disp;
    logic            br_taken;
    logic            br_pred_taken;
    logic [AWID-1:0] br_pred_tgt;

    logic            redirect_valid;
    logic [TIDW-1:0] redirect_tid;
    logic [AWID-1:0] redirect_pc;
    logic            redirect_ack;

    logic [NTHREADS-1:0] flush_mask;

    logic            upd_valid;
    logic [AWID-1:0] upd_pc;
    logic            upd_taken;

    modport master (
        output br_valid, br_tid, br_pc, br_disp, br_taken, br_pred_taken, br_pred_tgt,
        output redirect_ack,
        input  br_ready, redirect_valid, redirect_tid, redirect_pc, flush_mask,
        input  upd_valid, upd_pc, upd_taken
    );

    modport slave (
        input  br_valid, br_tid, br_pc, br_disp, br_taken, br_pred_taken, br_pred_tgt,
        input  redirect_ack,
        output br_ready, redirect_valid, redirect_tid, redirect_pc, flush_mask,
        output upd_valid, upd_pc, upd_taken
    );

endinterface

// File: rtl/rfphoenix_branch_target.sv
// Combinational next-PC and mispredict computation; wrap-around is modulo 2^AWID.
module rfphoenix_branch_target
    import rfphoenix_branch_resolve_pkg::*;
#(
    parameter int AWID       = 32,
    parameter int DWID       = 21,
    parameter int INSN_BYTES = INSN_BYTES_DEF
) (
    input  logic [AWID-1:0] pc,
    input  logic [DWID-1:0] disp,
    input  logic            taken,
    input  logic            pred_taken,
    input  logic [AWID-1:0] pred_tgt,
    output logic [AWID-1:0] actual,
    output logic            mispredict
);

    logic [AWID-1:0] tgt;
    logic [AWID-1:0] fall;

    assign tgt        = pc + {{(AWID-DWID){disp[DWID-1]}}, disp};
    assign fall       = pc + AWID'(INSN_BYTES);
    assign actual     = taken ? tgt : fall;
    assign mispredict = (taken != pred_taken) || (actual != pred_tgt);

endmodule

// File: rtl/rfphoenix_branch_resolve.sv
// Branch resolve: registered predictor update, held redirect and per-thread flush.
// Optional saturating counters behind RFPHOENIX_BRANCH_STATS_EN.
module rfphoenix_branch_resolve
    import rfphoenix_branch_resolve_pkg::*;
#(
    parameter int NTHREADS   = 4,
    parameter int AWID       = 32,
    parameter int DWID       = 21,
    parameter int INSN_BYTES = INSN_BYTES_DEF,
    parameter int FLUSH_CYC  = FLUSH_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    rfphoenix_branch_resolve_if.slave bus,
    output br_resolve_state_e state_dbg
`ifdef RFPHOENIX_BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int TIDW = $clog2(NTHREADS);
    localparam int CW   = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);

    br_resolve_state_e   state, state_n;
    logic                rv_q, rv_n;
    logic [TIDW-1:0]     rtid_q, rtid_n;
    logic [AWID-1:0]     rpc_q, rpc_n;
    logic [NTHREADS-1:0] mask_q, mask_n;
    logic                upd_v_q, upd_v_n;
    logic [AWID-1:0]     upd_pc_q, upd_pc_n;
    logic                upd_tk_q, upd_tk_n;
    logic [CW-1:0]       cnt_q, cnt_n;

    logic            accept;
    logic [AWID-1:0] actual;
    logic            mispredict;

    rfphoenix_branch_target #(
        .AWID       (AWID),
        .DWID       (DWID),
        .INSN_BYTES (INSN_BYTES)
    ) u_target (
        .pc         (bus.br_pc),
        .disp       (bus.br_disp),
        .taken      (bus.br_taken),
        .pred_taken (bus.br_pred_taken),
        .pred_tgt   (bus.br_pred_tgt),
        .actual     (actual),
        .mispredict (mispredict)
    );

    assign accept = bus.br_valid && (state == BRS_IDLE);

    always_comb begin
        state_n  = state;
        rv_n     = rv_q;
        rtid_n   = rtid_q;
        rpc_n    = rpc_q;
        mask_n   = mask_q;
        upd_v_n  = 1'b0;
        upd_pc_n = upd_pc_q;
        upd_tk_n = upd_tk_q;
        cnt_n    = cnt_q;
        case (state)
            BRS_IDLE: begin
                if (accept) begin
                    upd_v_n  = 1'b1;
                    upd_pc_n = bus.br_pc;
                    upd_tk_n = bus.br_taken;
                    if (mispredict) begin
                        rv_n    = 1'b1;
                        rtid_n  = bus.br_tid;
                        rpc_n   = actual;
                        mask_n  = NTHREADS'(1) << bus.br_tid;
                        state_n = BRS_REDIRECT;
                    end
                end
            end
            BRS_REDIRECT: begin
                if (bus.redirect_ack) begin
                    rv_n = 1'b0;
                    if (FLUSH_CYC == 0) begin
                        mask_n  = '0;
                        state_n = BRS_IDLE;
                    end else begin
                        cnt_n   = CW'(FLUSH_CYC);
                        state_n = BRS_FLUSH;
                    end
                end
            end
            BRS_FLUSH: begin
                if (cnt_q == CW'(1)) begin
                    cnt_n   = '0;
                    mask_n  = '0;
                    state_n = BRS_IDLE;
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            default: begin
                state_n = BRS_IDLE;
                rv_n    = 1'b0;
                mask_n  = '0;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BRS_IDLE;
            rv_q     <= 1'b0;
            rtid_q   <= '0;
            rpc_q    <= '0;
            mask_q   <= '0;
            upd_v_q  <= 1'b0;
            upd_pc_q <= '0;
            upd_tk_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state    <= state_n;
            rv_q     <= rv_n;
            rtid_q   <= rtid_n;
            rpc_q    <= rpc_n;
            mask_q   <= mask_n;
            upd_v_q  <= upd_v_n;
            upd_pc_q <= upd_pc_n;
            upd_tk_q <= upd_tk_n;
            cnt_q    <= cnt_n;
        end
    end

    assign bus.br_ready       = (state == BRS_IDLE);
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_tid   = rtid_q;
    assign bus.redirect_pc    = rpc_q;
    assign bus.flush_mask     = mask_q;
    assign bus.upd_valid      = upd_v_q;
    assign bus.upd_pc         = upd_pc_q;
    assign bus.upd_taken      = upd_tk_q;
    assign state_dbg          = state;

`ifdef RFPHOENIX_BRANCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (accept) begin
            if (stat_branches != '1)
                stat_branches <= stat_branches + 32'd1;
            if (mispredict && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule
